ifu_fetch: RTL

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/mips_pkg.sv | 21 ++
 rtl/ifu_queue.sv | 76 +++++++
 rtl/ifu_fetch.sv | 89 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction fetch unit: fetch FSM
// encoding, instruction/PC widths, reset vector and the queue entry layout.
package mips_pkg;

    localparam int XLEN  = 32;
    localparam int IM_AW = 10;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] word;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_queue.sv
// Small FIFO of fetched {word, pc} entries with flush; the head is read
// combinationally so the consumer sees it as soon as it is written.
module ifu_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic         one_left
);

    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SLOTS = 2 ** PW;

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    fetch_entry_t  mem [SLOTS];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full     = (cnt == CNT_FULL);
    assign empty    = (cnt == '0);
    assign one_left = (cnt == CNT_LAST);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            // NOTE: the storage is reset too, because the head drives
            // instr/instr_pc directly and those must read zero in reset.
            for (int i = 0; i < SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: sequential PC generation, redirect handling and a
// fetch queue. Define IFU_PREFETCH_EN for a 2-deep queue (1 instr/cycle).
module ifu_fetch
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              PC_STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IM_AW-1:0] im_addr,
    input  logic [XLEN-1:0]  im_dout,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [XLEN-1:0]  instr,
    output logic [XLEN-1:0]  instr_pc,
    output logic [XLEN-1:0]  instr_pc4
);

`ifdef IFU_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    fetch_state_e    state;
    logic [XLEN-3:0] pc_word;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_next;
    logic            push;
    logic            pop;
    logic            q_full;
    logic            q_empty;
    logic            q_one_left;
    fetch_entry_t    q_head;
    fetch_entry_t    q_in;

    // Only the word-aligned part of the PC is stored, so bits [1:0] are zero.
    assign fetch_pc = {pc_word, 2'b00};
    assign pc_next  = fetch_pc + 32'(PC_STEP);
    assign im_addr  = fetch_pc[IM_AW+1:2];

    assign pop  = instr_valid && instr_ready;
    assign push = (state == ST_FETCH) && !redirect_valid && (!q_full || pop);
    assign q_in = '{word: im_dout, pc: fetch_pc};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_word <= RESET_PC[XLEN-1:2];
            state   <= ST_IDLE;
        end else if (redirect_valid) begin
            pc_word <= (XLEN-2)'(redirect_pc >> 2);
            state   <= ST_FETCH;
        end else begin
            if (push) begin
                pc_word <= (XLEN-2)'(pc_next >> 2);
            end
            case (state)
                ST_IDLE:  state <= ST_FETCH;
                ST_FETCH: if (push && !pop && q_one_left) state <= ST_FULL;
                ST_FULL:  if (pop) state <= ST_FETCH;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    ifu_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (q_in),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .one_left  (q_one_left)
    );

    assign instr_valid = !q_empty;
    assign instr       = q_head.word;
    assign instr_pc    = q_head.pc;
    assign instr_pc4   = q_head.pc + 32'd4;

endmodule
